uart_tx_fifo: RTL and testbench

//   FIFO-buffered UART transmitter, 8N1, LSB first. It is the upstream partner of the receive path.

---
 rtl/uart_tx_fifo_if.sv | 34 +++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Host-side bundle for the FIFO-buffered UART transmitter.
//   Signals:
//     wr_en       host -> tx   push din into the FIFO this cycle
//     din[7:0]    host -> tx   byte to transmit
//     tx          tx -> host   serial line, idle high
//     tx_busy     tx -> host   a frame is on the line
//     fifo_full   tx -> host   FIFO holds DEPTH entries
//     fifo_empty  tx -> host   FIFO holds no entries
//     fifo_count  tx -> host   entries currently stored
//   Modports: master = host logic, slave = the transmitter.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    din;
  logic          tx;
  logic          tx_busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  modport master (
    output wr_en, din,
    input  tx, tx_busy, fifo_full, fifo_empty, fifo_count
  );

  modport slave (
    input  wr_en, din,
    output tx, tx_busy, fifo_full, fifo_empty, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   FIFO-buffered 8N1 UART transmitter, LSB first. Host bytes are queued in
//   an internal DEPTH-entry FIFO and serialised one frame at a time.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   uart_tx_fifo_if.slave (wr_en, din, tx, tx_busy, fifo_full,
//           fifo_empty, fifo_count)
//   Parameters: CLK_FREQ (Hz), BAUD_RATE (bit/s), DEPTH (power of 2, >= 2).
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DEPTH     = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W     = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CW        = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICK - 1);
  localparam logic [CW-1:0]    COUNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push;
  logic             pop;

  // ----------------------------------------------------------------- FSM
  state_t           state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             bit_end;

  // The registered full flag gates writes, so a write while full is lost
  // even if the FSM frees a slot in the same cycle.
  assign push    = bus.wr_en & ~full_reg;
  // The FSM pops exactly when it leaves IDLE with data available.
  assign pop     = (state_reg == IDLE) & ~empty_reg;
  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset: discarding contents is done by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      // Pointers are PTR_W wide, so DEPTH being a power of 2 gives the wrap.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_MAX);
      empty_reg <= (count_next == '0);
    end
  end

  // Line level follows the state held during the previous cycle, so tx
  // lags the state register by one clock: pop at n+1, start bit at n+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      unique case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      unique case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (!empty_reg) begin
            // Registered read of the FIFO head; the byte leaves the FIFO
            // here, before its start bit goes out.
            shift_reg   <= mem[rd_ptr_reg];
            bit_idx_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_reg;
  assign bus.tx_busy    = busy_reg;
  assign bus.fifo_full  = full_reg;
  assign bus.fifo_empty = empty_reg;
  assign bus.fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with BAUD_TICK = 10 and DEPTH = 16.
//   A serial monitor decodes frames from tx into a byte queue; the main
//   sequence compares line timing, FIFO status and decoded bytes against
//   hand-computed values.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int TICK  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passed = 0;
  int         now_e  = 0;
  logic [7:0] rx_q[$];
  logic       stop_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance k rising edges; sample/drive 1 ns after each edge.
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      now_e++;
    end
  endtask

  task automatic go_to(input int e);
    if (e > now_e) step(e - now_e);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      step(1);
      c++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (bus.tx_busy !== 1'b0 && c < budget) begin
      step(1);
      c++;
    end
    check(tag, {31'd0, bus.tx_busy}, 0);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] e);
    logic [7:0] b;
    logic       s;
    b = 8'hxx;
    s = 1'bx;
    if (rx_q.size() > 0) begin
      b = rx_q.pop_front();
      s = stop_q.pop_front();
    end
    check(tag, {24'd0, b}, {24'd0, e});
    check({tag, "_stop"}, {31'd0, s}, 1);
  endtask

  // Serial monitor: detect the falling start edge, sample each bit near
  // its middle, drop any frame interrupted by reset.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    logic       ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && bus.tx === 1'b0 && rst === 1'b0) begin
        ab = 1'b0;
        b  = '0;
        repeat (TICK / 2 - 1) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (TICK) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          b[i] = bus.tx;
        end
        repeat (TICK) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        if (!ab) begin
          rx_q.push_back(b);
          stop_q.push_back(bus.tx);
        end
      end
      prev = bus.tx;
    end
  end

  initial begin : main
    logic [7:0] v;
    logic [7:0] data [36];
    logic       seen_low;
    int         sent;
    int         guard;

    bus.wr_en = 1'b0;
    bus.din   = 8'h00;

    // 1. reset state
    rst = 1'b1;
    step(3);
    check("rst_tx", {31'd0, bus.tx}, 1);
    check("rst_busy", {31'd0, bus.tx_busy}, 0);
    check("rst_empty", {31'd0, bus.fifo_empty}, 1);
    check("rst_full", {31'd0, bus.fifo_full}, 0);
    check("rst_count", {27'd0, bus.fifo_count}, 0);
    rst = 1'b0;
    step(2);
    check("idle_tx", {31'd0, bus.tx}, 1);

    // 2. single byte 0xA5: write edge is n = 0
    bus.din   = 8'hA5;
    bus.wr_en = 1'b1;
    now_e     = -1;
    step(1);
    bus.wr_en = 1'b0;
    check("t2_count_n", {27'd0, bus.fifo_count}, 1);
    check("t2_empty_n", {31'd0, bus.fifo_empty}, 0);
    go_to(1);
    check("t2_busy_n1", {31'd0, bus.tx_busy}, 1);
    check("t2_tx_n1", {31'd0, bus.tx}, 1);
    check("t2_count_n1", {27'd0, bus.fifo_count}, 0);
    go_to(2);
    check("t2_start_n2", {31'd0, bus.tx}, 0);
    go_to(11);
    check("t2_start_n11", {31'd0, bus.tx}, 0);
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      go_to(17 + 10 * i);
      check($sformatf("t2_bit%0d", i), {31'd0, bus.tx}, {31'd0, v[i]});
    end
    go_to(97);
    check("t2_stop", {31'd0, bus.tx}, 1);
    go_to(100);
    check("t2_busy_n100", {31'd0, bus.tx_busy}, 1);
    go_to(101);
    check("t2_busy_n101", {31'd0, bus.tx_busy}, 0);
    wait_rx("t2_rx_count", 1, 50);
    check_rx("t2_rx", 8'hA5);

    // 3. burst 0x00..0x11; 0x11 arrives while full and is dropped
    wait_idle("t3_idle", 200);
    step(1);
    bus.wr_en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      bus.din = 8'(k);
      step(1);
      if (k == 15) check("t3_full_w16", {31'd0, bus.fifo_full}, 0);
      if (k == 16) begin
        check("t3_full_w17", {31'd0, bus.fifo_full}, 1);
        check("t3_count_w17", {27'd0, bus.fifo_count}, 16);
      end
    end
    bus.wr_en = 1'b0;
    check("t3_count_w18", {27'd0, bus.fifo_count}, 16);
    wait_rx("t3_rx_count", 17, 17 * 101 + 100);
    for (int k = 0; k < 17; k++) begin
      check_rx($sformatf("t3_rx%0d", k), 8'(k));
    end
    wait_idle("t3_idle_end", 200);
    check("t3_empty_end", {31'd0, bus.fifo_empty}, 1);
    check("t3_count_end", {27'd0, bus.fifo_count}, 0);
    check("t3_no_extra", rx_q.size(), 0);

    // 4. push and pop in the same cycle with 5 queued
    step(1);
    bus.wr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.din = 8'h31 + 8'(k);
      step(1);
    end
    bus.wr_en = 1'b0;
    check("t4_count5", {27'd0, bus.fifo_count}, 5);
    wait_idle("t4_gap", 200);
    check("t4_count_gap", {27'd0, bus.fifo_count}, 5);
    bus.din   = 8'h37;
    bus.wr_en = 1'b1;
    step(1);
    bus.wr_en = 1'b0;
    check("t4_count_pushpop", {27'd0, bus.fifo_count}, 5);
    check("t4_busy_pushpop", {31'd0, bus.tx_busy}, 1);
    wait_rx("t4_rx_count", 7, 7 * 101 + 100);
    for (int k = 0; k < 7; k++) begin
      check_rx($sformatf("t4_rx%0d", k), 8'h31 + 8'(k));
    end
    wait_idle("t4_idle_end", 200);
    check("t4_empty_end", {31'd0, bus.fifo_empty}, 1);

    // 5. reset in the middle of the 0x3C data bits with 4 bytes queued
    step(1);
    now_e     = -1;
    bus.wr_en = 1'b1;
    bus.din   = 8'h3C; step(1);
    bus.din   = 8'hD1; step(1);
    bus.din   = 8'hD2; step(1);
    bus.din   = 8'hD3; step(1);
    bus.din   = 8'hD4; step(1);
    bus.wr_en = 1'b0;
    check("t5_count4", {27'd0, bus.fifo_count}, 4);
    go_to(50);
    check("t5_busy_mid", {31'd0, bus.tx_busy}, 1);
    rst = 1'b1;
    step(1);
    check("t5_tx", {31'd0, bus.tx}, 1);
    check("t5_count", {27'd0, bus.fifo_count}, 0);
    check("t5_empty", {31'd0, bus.fifo_empty}, 1);
    check("t5_full", {31'd0, bus.fifo_full}, 0);
    check("t5_busy", {31'd0, bus.tx_busy}, 0);
    rst = 1'b0;
    seen_low = 1'b0;
    repeat (400) begin
      step(1);
      if (bus.tx !== 1'b1) seen_low = 1'b1;
    end
    check("t5_line_quiet", {31'd0, seen_low}, 0);
    check("t5_no_frames", rx_q.size(), 0);

    // 6. enough bytes to wrap both pointers twice, random write strobe,
    //    writing only while not full
    for (int k = 0; k < 36; k++) data[k] = 8'($urandom_range(0, 255));
    sent  = 0;
    guard = 0;
    while (sent < 36 && guard < 8000) begin
      if (!bus.fifo_full && ($urandom_range(0, 1) == 1)) begin
        bus.din   = data[sent];
        bus.wr_en = 1'b1;
        sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
      step(1);
      guard++;
    end
    bus.wr_en = 1'b0;
    check("t6_sent", sent, 36);
    wait_rx("t6_rx_count", 36, 36 * 101 + 200);
    for (int k = 0; k < 36; k++) begin
      check_rx($sformatf("t6_rx%0d", k), data[k]);
    end
    wait_idle("t6_idle_end", 200);
    check("t6_empty_end", {31'd0, bus.fifo_empty}, 1);
    check("t6_count_end", {27'd0, bus.fifo_count}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
